vram_oled_scan: RTL and testbench



---
 rtl/vram_oled_scan.sv | 175 +++++++++++++++++
 tb/tb_vram_oled_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_oled_scan.sv
// vram_oled_scan: streams the 128x32x1bpp framebuffer to an SSD1306-class
// OLED over write-only SPI (mode 0, MSB first). Every frame starts with a
// six-byte column/page window preamble, then 512 page-format data bytes.
// Each data byte is built from eight vertically adjacent pixels read back
// from VRAM with a fixed two-clock latency.
module vram_oled_scan #(
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_GAP = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        en_i,
  output logic [11:0] gb_adr_o,
  input  logic        gb_pix_i,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  output logic        spi_dc_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
  localparam int GAP_W = $clog2(REFRESH_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       cmd_idx;
  logic [6:0]       col;
  logic [1:0]       page;
  logic [3:0]       fetch_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       pix_byte;
  logic [11:0]      adr_q;
  logic [7:0]       cmd_cur;
  logic [2:0]       pix_bit;
  logic             bit_end;
  logic             byte_end;
  logic             cmd_last;
  logic             frame_last;
  logic             gap_end;
  logic             sending;

  // Preamble: column window 0..127, page window 0..3.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h21;
      3'd1:    return 8'h00;
      3'd2:    return 8'h7F;
      3'd3:    return 8'h22;
      3'd4:    return 8'h00;
      default: return 8'h03;
    endcase
  endfunction

  assign cmd_cur    = cmd_byte(cmd_idx);
  assign sending    = (state == S_CMD) || (state == S_SHIFT);
  assign bit_end    = (div_cnt == DIV_LAST);
  assign byte_end   = bit_end && (bit_cnt == 3'd7);
  assign cmd_last   = (cmd_idx == 3'd5);
  assign frame_last = (page == 2'd3) && (col == 7'd127);
  assign gap_end    = (gap_cnt == GAP_LAST);
  // Pixel for address issued on fetch clock b arrives on fetch clock b+2.
  assign pix_bit    = 3'(fetch_cnt - 4'd2);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and Moore outputs derived from state and counters.
  always_comb begin
    state_nxt    = state;
    spi_cs_n_o   = 1'b1;
    spi_sck_o    = 1'b0;
    spi_mosi_o   = 1'b0;
    spi_dc_o     = 1'b0;
    frame_done_o = 1'b0;
    gb_adr_o     = adr_q;
    case (state)
      S_IDLE: begin
        if (en_i) state_nxt = S_CMD;
      end
      S_CMD: begin
        spi_cs_n_o = 1'b0;
        spi_sck_o  = (div_cnt >= DIV_HIGH);
        spi_mosi_o = cmd_cur[3'd7 - bit_cnt];
        if (byte_end && cmd_last) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        spi_cs_n_o = 1'b0;
        spi_dc_o   = 1'b1;
        if (fetch_cnt < 4'd8) gb_adr_o = {col, page, fetch_cnt[2:0]};
        if (fetch_cnt == 4'd9) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        spi_cs_n_o = 1'b0;
        spi_dc_o   = 1'b1;
        spi_sck_o  = (div_cnt >= DIV_HIGH);
        spi_mosi_o = pix_byte[3'd7 - bit_cnt];
        if (byte_end) state_nxt = frame_last ? S_GAP : S_FETCH;
      end
      S_GAP: begin
        frame_done_o = (gap_cnt == '0);
        if (gap_end) state_nxt = en_i ? S_CMD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_o = ~spi_cs_n_o;
  end

  // Bit/byte timing, preamble index, fetch, scan position and gap counters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cmd_idx   <= '0;
      fetch_cnt <= '0;
      col       <= '0;
      page      <= '0;
      gap_cnt   <= '0;
      adr_q     <= '0;
    end else begin
      adr_q <= gb_adr_o;

      if (sending) begin
        div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
        if (bit_end) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end

      if (state == S_CMD) begin
        if (byte_end) cmd_idx <= cmd_last ? 3'd0 : cmd_idx + 3'd1;
      end else begin
        cmd_idx <= '0;
      end

      if (state == S_FETCH) fetch_cnt <= (fetch_cnt == 4'd9) ? 4'd0 : fetch_cnt + 4'd1;
      else                  fetch_cnt <= '0;

      if ((state == S_SHIFT) && byte_end) begin
        col <= col + 7'd1;
        if (col == 7'd127) page <= page + 2'd1;
      end else if ((state == S_IDLE) || (state == S_GAP)) begin
        col  <= '0;
        page <= '0;
      end

      if (state == S_GAP) gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
      else                gap_cnt <= '0;
    end
  end

  // Pixel assembly into the page byte; bit 0 is the top row of the page.
  always_ff @(posedge wb_clk_i) begin
    if ((state == S_FETCH) && (fetch_cnt >= 4'd2)) pix_byte[pix_bit] <= gb_pix_i;
  end

endmodule

// File: tb/tb_vram_oled_scan.sv
// Directed bench for vram_oled_scan: VRAM model with one lit pixel, SPI
// decoder feeding a byte scoreboard, plus frame/gap length and pulse checks.
module tb_vram_oled_scan;

  localparam int CLK_DIV  = 2;
  localparam int GAP      = 16;
  localparam int LOW_LEN  = 96 * CLK_DIV + 512 * (10 + 16 * CLK_DIV);
  localparam int LIM      = 30000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        en_i     = 1'b1;
  logic [11:0] gb_adr_o;
  logic        gb_pix_i;
  logic        spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_dc_o, busy_o, frame_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] cmd_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  // VRAM model: only pixel (x=5, y=9) is set, two-clock read latency.
  logic vp1 = 1'b0, vp2 = 1'b0;
  always @(posedge wb_clk_i) begin
    vp1 <= (gb_adr_o == 12'h0A9);
    vp2 <= vp1;
  end
  assign gb_pix_i = vp2;

  vram_oled_scan #(.CLK_DIV(CLK_DIV), .REFRESH_GAP(GAP)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .en_i        (en_i),
    .gb_adr_o    (gb_adr_o),
    .gb_pix_i    (gb_pix_i),
    .spi_sck_o   (spi_sck_o),
    .spi_mosi_o  (spi_mosi_o),
    .spi_cs_n_o  (spi_cs_n_o),
    .spi_dc_o    (spi_dc_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, cmd_tab[i]});
    for (int i = 0; i < 512; i++) exp_q.push_back({1'b1, (i == 133) ? 8'h02 : 8'h00});
  endtask

  // SPI decoder and frame/gap measurement, sampled on the falling clock edge.
  logic       sck_d = 1'b0, cs_d = 1'b1;
  logic [6:0] rx_sh = '0;
  logic [2:0] rx_bits = '0;
  logic [7:0] first_byte = '0;
  int rx_cnt = 0, data_cnt = 0, low_cnt = 0, high_cnt = 0;
  int last_low = 0, last_high = 0, last_bytes = 0, fd_cnt = 0;

  always @(negedge wb_clk_i) begin
    sck_d <= spi_sck_o;
    cs_d  <= spi_cs_n_o;
    if (frame_done_o) fd_cnt <= fd_cnt + 1;
    if (spi_cs_n_o) begin
      high_cnt <= high_cnt + 1;
      if (!cs_d) begin
        last_low   <= low_cnt;
        last_bytes <= rx_cnt;
      end
      low_cnt    <= 0;
      rx_bits    <= '0;
      rx_cnt     <= 0;
      data_cnt   <= 0;
      first_byte <= '0;
    end else begin
      low_cnt <= low_cnt + 1;
      if (cs_d) last_high <= high_cnt;
      high_cnt <= 0;
      if (spi_sck_o && !sck_d) begin
        rx_sh   <= {rx_sh[5:0], spi_mosi_o};
        rx_bits <= rx_bits + 3'd1;
        if (rx_bits == 3'd7) begin
          if (exp_q.size() == 0)
            check("spi_unexpected_byte", 32'(exp_q.size()), 32'd1);
          else
            check("spi_byte", 32'({spi_dc_o, rx_sh, spi_mosi_o}), 32'(exp_q.pop_front()));
          rx_cnt <= rx_cnt + 1;
          if (spi_dc_o) data_cnt <= data_cnt + 1;
          if (rx_cnt == 0) first_byte <= {rx_sh, spi_mosi_o};
        end
      end
    end
  end

  initial begin
    int t;
    int fd_before;

    // Reset held 3 clocks with en_i high.
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("rst_sck", 32'(spi_sck_o), 32'd0);
    check("rst_mosi", 32'(spi_mosi_o), 32'd0);
    check("rst_dc", 32'(spi_dc_o), 32'd0);
    check("rst_adr", 32'(gb_adr_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    push_frame();
    push_frame();
    wb_rst_i = 1'b0;

    // First CS fall on the clock after release.
    @(negedge wb_clk_i);
    check("cs_fall_after_rst", 32'(spi_cs_n_o), 32'd0);
    check("busy_in_cmd", 32'(busy_o), 32'd1);
    check("dc_in_cmd", 32'(spi_dc_o), 32'd0);

    // Preamble length, then first FETCH addresses.
    t = 0;
    while (!spi_dc_o && t < 1000) begin @(negedge wb_clk_i); t++; end
    check("preamble_clocks", 32'(t), 32'(96 * CLK_DIV));
    for (int i = 0; i < 10; i++) begin
      if (i < 8) check("fetch_adr", 32'(gb_adr_o), 32'(i));
      check("fetch_sck_low", 32'(spi_sck_o), 32'd0);
      @(negedge wb_clk_i);
    end

    // End of frame 1.
    t = 0;
    while (!frame_done_o && t < LIM) begin @(negedge wb_clk_i); t++; end
    check("frame1_done_seen", 32'(t < LIM), 32'd1);
    check("done_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("done_busy", 32'(busy_o), 32'd0);
    @(negedge wb_clk_i);
    check("done_single_pulse", 32'(frame_done_o), 32'd0);
    check("frame1_low_len", 32'(last_low), 32'(LOW_LEN));
    check("frame1_bytes", 32'(last_bytes), 32'd518);
    check("frame1_done_cnt", 32'(fd_cnt), 32'd1);

    // Gap before frame 2.
    t = 0;
    while (spi_cs_n_o && t < 100) begin @(negedge wb_clk_i); t++; end
    @(negedge wb_clk_i);
    check("gap_len", 32'(last_high), 32'(GAP));

    // Drop en_i during data byte 200 of frame 2.
    t = 0;
    while (data_cnt != 200 && t < LIM) begin @(negedge wb_clk_i); t++; end
    check("byte200_reached", 32'(t < LIM), 32'd1);
    en_i = 1'b0;
    t = 0;
    while (!frame_done_o && t < LIM) begin @(negedge wb_clk_i); t++; end
    check("frame2_done_seen", 32'(t < LIM), 32'd1);
    @(negedge wb_clk_i);
    check("frame2_low_len", 32'(last_low), 32'(LOW_LEN));
    check("frame2_bytes", 32'(last_bytes), 32'd518);
    check("frame2_done_cnt", 32'(fd_cnt), 32'd2);
    repeat (40) @(negedge wb_clk_i);
    check("idle_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_no_frame", 32'(fd_cnt), 32'd2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset during bit 3 of data byte 50.
    push_frame();
    en_i = 1'b1;
    t = 0;
    while (!(data_cnt == 50 && rx_bits == 3'd4) && t < LIM) begin @(negedge wb_clk_i); t++; end
    check("byte50_reached", 32'(t < LIM), 32'd1);
    @(negedge wb_clk_i);
    fd_before = fd_cnt;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("midrst_sck", 32'(spi_sck_o), 32'd0);
    check("midrst_mosi", 32'(spi_mosi_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_done", 32'(frame_done_o), 32'd0);
      @(negedge wb_clk_i);
    end
    exp_q.delete();
    push_frame();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("restart_cs_fall", 32'(spi_cs_n_o), 32'd0);
    t = 0;
    while (rx_cnt < 7 && t < 2000) begin @(negedge wb_clk_i); t++; end
    check("restart_bytes_seen", 32'(t < 2000), 32'd1);
    check("restart_first_byte", 32'(first_byte), 32'h21);
    check("midrst_done_cnt", 32'(fd_cnt), 32'(fd_before));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
